vga_scan_pipe: RTL

- Parametrised VGA scan engine: raster timing generator, image-window address generator for a synchronous pixel memory, and RGB888-to-RGBn conversion in one block.
- Image is placed at a runtime offset and integer-scaled by 2^SCALE_SHIFT.
- Sits between the system clock divider (pixel-rate enable) and the pixel ROM/RAM.
- Sync/data pipeline is length-matched to a configurable memory read latency.

---
 rtl/vga_scan_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vga_scan_pipe.sv
// rtl/vga_scan_pipe.sv - VGA raster timing, image-window addressing and RGB output pipeline
// Optional 8-bar test pattern with input test_en when VGA_TEST_PATTERN_EN is defined.
module vga_scan_pipe #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 64,
   parameter int SCALE_SHIFT = 0,
   parameter int ADDR_W      = 12,
   parameter int MEM_LAT     = 1,
   parameter int COLOR_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_en,
   input  logic [10:0]            x_off,
   input  logic [9:0]             y_off,
   input  logic [3*COLOR_W-1:0]   bg_color,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_rd,
   input  logic [23:0]            mem_data,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                   test_en,
`endif
   output logic                   hs,
   output logic                   vs,
   output logic                   de,
   output logic [COLOR_W-1:0]     r,
   output logic [COLOR_W-1:0]     g,
   output logic [COLOR_W-1:0]     b,
   output logic [9:0]             col_addr,
   output logic [8:0]             row_addr,
   output logic                   frame_start
);

   localparam logic [11:0] H_TOTAL  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [11:0] V_TOTAL  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
   localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
   localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
   localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
   localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
   localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [11:0] WIN_W    = 12'(IMG_W << SCALE_SHIFT);
   localparam logic [11:0] WIN_H    = 12'(IMG_H << SCALE_SHIFT);

   typedef struct packed {
      logic       tp;
      logic [2:0] bar;
      logic       hs;
      logic       vs;
      logic       de;
      logic       win;
      logic [9:0] col;
      logic [8:0] row;
   } stage_t;

   localparam stage_t STAGE_RST = '{tp: 1'b0, bar: 3'd0, hs: !HS_POL, vs: !VS_POL,
                                    de: 1'b0, win: 1'b0, col: 10'd0, row: 9'd0};

   logic [11:0]       h_cnt, v_cnt;
   logic [11:0]       xs_q, ys_q, xs, ys;
   logic [11:0]       dx, dy, sx, sy;
   logic [ADDR_W-1:0] addr_next;
   logic              at_origin, de_raw, in_win, test_act;
   logic [2:0]        bar;
   stage_t            s0, tail;
   stage_t            pipe [MEM_LAT];
   logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;
   logic [9:0]        col_nxt;
   logic [8:0]        row_nxt;
   logic              unused_bits;

   assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
   // The origin pixel already sees the offsets that are being latched for its frame.
   assign xs = at_origin ? {1'b0, x_off} : xs_q;
   assign ys = at_origin ? {2'b00, y_off} : ys_q;

   assign de_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign in_win = de_raw && (h_cnt >= xs) && (h_cnt < xs + WIN_W)
                          && (v_cnt >= ys) && (v_cnt < ys + WIN_H);

   assign dx        = h_cnt - xs;
   assign dy        = v_cnt - ys;
   assign sx        = dx >> SCALE_SHIFT;
   assign sy        = dy >> SCALE_SHIFT;
   assign addr_next = ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx);

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [11:0] BAR_W = 12'(H_VISIBLE / 8);
   assign test_act = test_en && de_raw;
   assign bar      = 3'(h_cnt / BAR_W);
`else
   assign test_act = 1'b0;
   assign bar      = 3'd0;
`endif

   always_comb begin
      s0     = STAGE_RST;
      s0.tp  = test_act;
      s0.bar = bar;
      s0.hs  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : !HS_POL;
      s0.vs  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : !VS_POL;
      s0.de  = de_raw;
      s0.win = in_win && !test_act;
      s0.col = h_cnt[9:0];
      s0.row = v_cnt[8:0];
   end

   assign tail = pipe[MEM_LAT-1];

   always_comb begin
      r_nxt   = '0;
      g_nxt   = '0;
      b_nxt   = '0;
      col_nxt = '0;
      row_nxt = '0;
      if (tail.de) begin
         col_nxt = tail.col;
         row_nxt = tail.row;
         if (tail.tp) begin
            r_nxt = {COLOR_W{~tail.bar[1]}};
            g_nxt = {COLOR_W{~tail.bar[2]}};
            b_nxt = {COLOR_W{~tail.bar[0]}};
         end else if (tail.win) begin
            r_nxt = mem_data[23 -: COLOR_W];
            g_nxt = mem_data[15 -: COLOR_W];
            b_nxt = mem_data[7 -: COLOR_W];
         end else begin
            r_nxt = bg_color[3*COLOR_W-1 -: COLOR_W];
            g_nxt = bg_color[2*COLOR_W-1 -: COLOR_W];
            b_nxt = bg_color[COLOR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         xs_q        <= '0;
         ys_q        <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         frame_start <= 1'b0;
         for (int i = 0; i < MEM_LAT; i++) pipe[i] <= STAGE_RST;
         hs          <= !HS_POL;
         vs          <= !VS_POL;
         de          <= 1'b0;
         r           <= '0;
         g           <= '0;
         b           <= '0;
         col_addr    <= '0;
         row_addr    <= '0;
      end else begin
         frame_start <= pix_en && at_origin;
         if (pix_en) begin
            if (h_cnt == H_TOTAL - 12'd1) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
            end else begin
               h_cnt <= h_cnt + 12'd1;
            end
            if (at_origin) begin
               xs_q <= xs;
               ys_q <= ys;
            end
            mem_rd <= s0.win;
            if (s0.win) mem_addr <= addr_next;
            pipe[0] <= s0;
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
            hs       <= tail.hs;
            vs       <= tail.vs;
            de       <= tail.de;
            r        <= r_nxt;
            g        <= g_nxt;
            b        <= b_nxt;
            col_addr <= col_nxt;
            row_addr <= row_nxt;
         end
      end
   end

   assign unused_bits = ^{mem_data, sx, sy};

endmodule
